// File: rtl/byte_ram_responder.sv
// byte_ram_responder: byte-wide RAM plus memory-mapped UART TX FIFO and halt flag.
// RAM and FIFO storage are not reset; control state resets synchronously on rst.
module byte_ram_responder #(
    parameter int unsigned ADDR_WIDTH = 17,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    output logic        uart_full,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        overflow,
    output logic        halt
);

    localparam int unsigned MEM_DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;
    localparam logic [17:0] UART_ADDR = 18'h30000;
    localparam logic [17:0] HALT_ADDR = 18'h30004;

    logic [7:0]            mem [MEM_DEPTH];
    logic [7:0]            fifo_buf [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;

    logic                  is_io;
    logic                  uart_sel;
    logic                  halt_sel;
    logic [ADDR_WIDTH-1:0] ram_a;
    logic [7:0]            io_rd;
    logic                  fifo_full;
    logic                  push_req;
    logic                  push;
    logic                  pop;
    logic                  drop;
    logic                  unused_addr;

    // Address decode: bits above 17 alias, IO window is addr[17:16] == 2'b11
    always_comb begin
        is_io       = (addr[17:16] == 2'b11);
        ram_a       = addr[ADDR_WIDTH-1:0];
        uart_sel    = is_io && (addr[17:0] == UART_ADDR);
        halt_sel    = is_io && (addr[17:0] == HALT_ADDR);
        io_rd       = halt_sel ? 8'(count) : 8'h00;
        unused_addr = ^addr[31:18];
    end

    // FIFO handshake; a push at full is still accepted when a pop frees a slot
    always_comb begin
        tx_valid  = (count != '0);
        tx_data   = fifo_buf[rd_ptr];
        uart_full = (count >= CNT_W'(FIFO_DEPTH - 1));
        fifo_full = (count == CNT_W'(FIFO_DEPTH));
        pop       = tx_valid && tx_ready;
        push_req  = wr && uart_sel;
        push      = push_req && (!fifo_full || pop);
        drop      = push_req && fifo_full && !pop;
    end

    // RAM write port (contents survive reset)
    always_ff @(posedge clk) begin
        if (wr && !is_io) begin
            mem[ram_a] <= din;
        end
    end

    // Registered read data; write cycles leave dout unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= 8'h00;
        end else if (!wr) begin
            if (is_io) begin
                dout <= io_rd;
            end else begin
                dout <= mem[ram_a];
            end
        end
    end

    // FIFO storage write (contents are don't-care after reset)
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_buf[wr_ptr] <= din;
        end
    end

    // FIFO pointers, occupancy and sticky status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            halt     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
            if (wr && halt_sel) begin
                halt <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_byte_ram_responder.sv
// Self-checking bench for byte_ram_responder: vector table plus directed FIFO/reset sequences.
module tb_byte_ram_responder;

    logic        clk;
    logic        rst;
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        uart_full;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        overflow;
    logic        halt;

    byte_ram_responder #(.ADDR_WIDTH(17), .FIFO_DEPTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr        (wr),
        .addr      (addr),
        .din       (din),
        .dout      (dout),
        .uart_full (uart_full),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .overflow  (overflow),
        .halt      (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [7:0]  d;
        logic [7:0]  exp;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [7:0] ram_m [int unsigned];
    logic [7:0] txq [$];
    logic [7:0] dq [$];
    logic [7:0] last_dout_m;
    bit         overflow_m;
    bit         halt_m;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One bus cycle: predict, drive, clock, compare
    task automatic access(input bit w, input logic [31:0] a, input logic [7:0] d);
        bit          io;
        bit          pop_m;
        logic [7:0]  exp_d;
        int unsigned idx;
        wr   = w;
        addr = a;
        din  = d;
        check("tx_valid", 32'(tx_valid), 32'(txq.size() != 0));
        check("uart_full", 32'(uart_full), 32'(txq.size() >= 7));
        if (txq.size() != 0) check("tx_data", 32'(tx_data), 32'(txq[0]));
        io    = (a[17:16] == 2'b11);
        idx   = 32'(a[16:0]);
        pop_m = (txq.size() != 0) && tx_ready;
        if (w) begin
            exp_d = last_dout_m;
        end else if (io) begin
            exp_d = (a[17:0] == 18'h30004) ? 8'(txq.size()) : 8'h00;
        end else begin
            exp_d = ram_m.exists(idx) ? ram_m[idx] : 8'h00;
        end
        dq.push_back(exp_d);
        last_dout_m = exp_d;
        if (w && !io) ram_m[idx] = d;
        if (w && a[17:0] == 18'h30000) begin
            if (txq.size() == 8 && !pop_m) begin
                overflow_m = 1'b1;
                if (pop_m) void'(txq.pop_front());
            end else begin
                if (pop_m) void'(txq.pop_front());
                txq.push_back(d);
            end
        end else if (pop_m) begin
            void'(txq.pop_front());
        end
        if (w && a[17:0] == 18'h30004) halt_m = 1'b1;
        step();
        exp_d = dq.pop_front();
        check("dout", 32'(dout), 32'(exp_d));
        check("overflow", 32'(overflow), 32'(overflow_m));
        check("halt", 32'(halt), 32'(halt_m));
    endtask

    task automatic idle();
        access(1'b0, 32'h0003_0008, 8'h00);
    endtask

    // Reset for one cycle, optionally with a UART write on the bus that must be ignored
    task automatic do_reset(input bit with_write);
        rst  = 1'b1;
        wr   = with_write;
        addr = 32'h0003_0000;
        din  = 8'hEE;
        step();
        rst  = 1'b0;
        wr   = 1'b0;
        addr = 32'h0;
        din  = 8'h00;
        txq.delete();
        dq.delete();
        last_dout_m = 8'h00;
        overflow_m  = 1'b0;
        halt_m      = 1'b0;
        check("rst_dout", 32'(dout), 32'h0);
        check("rst_tx_valid", 32'(tx_valid), 32'h0);
        check("rst_uart_full", 32'(uart_full), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        check("rst_halt", 32'(halt), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl [13];
        logic [7:0] drain_exp [8];
        tbl[0]  = '{1'b1, 32'h0000_0010, 8'hA5, 8'h00};
        tbl[1]  = '{1'b0, 32'h0000_0010, 8'h00, 8'hA5};
        tbl[2]  = '{1'b0, 32'h0002_0010, 8'h00, 8'hA5};
        tbl[3]  = '{1'b1, 32'h0000_0000, 8'h3C, 8'hA5};
        tbl[4]  = '{1'b1, 32'h0000_0010, 8'h77, 8'hA5};
        tbl[5]  = '{1'b0, 32'h0000_0010, 8'h00, 8'h77};
        tbl[6]  = '{1'b0, 32'h0000_0000, 8'h00, 8'h3C};
        tbl[7]  = '{1'b1, 32'h0001_FFFF, 8'h99, 8'h3C};
        tbl[8]  = '{1'b0, 32'hFFFD_FFFF, 8'h00, 8'h99};
        tbl[9]  = '{1'b1, 32'h0003_0008, 8'h55, 8'h99};
        tbl[10] = '{1'b0, 32'h0003_0008, 8'h00, 8'h00};
        tbl[11] = '{1'b0, 32'h0003_0004, 8'h00, 8'h00};
        tbl[12] = '{1'b0, 32'h0000_0010, 8'h00, 8'h77};

        rst = 1'b1; wr = 1'b0; addr = 32'h0; din = 8'h00; tx_ready = 1'b0;
        last_dout_m = 8'h00; overflow_m = 1'b0; halt_m = 1'b0;
        step();
        do_reset(1'b0);

        // RAM vectors: round trip, alias, write-then-read, high-bit wrap, IO reads
        for (int i = 0; i < 13; i++) begin
            access(tbl[i].w, tbl[i].a, tbl[i].d);
            check($sformatf("vec%0d_dout", i), 32'(dout), 32'(tbl[i].exp));
        end

        // Read latency and hold
        access(1'b0, 32'h0000_0010, 8'h00);
        check("lat_first", 32'(dout), 32'h77);
        access(1'b0, 32'h0000_0000, 8'h00);
        check("lat_next", 32'(dout), 32'h3C);

        // Fill to full and overflow with the serializer stalled
        for (int i = 0; i < 9; i++) begin
            access(1'b1, 32'h0003_0000, 8'(8'h10 + i));
            if (i == 5) check("full_after6", 32'(uart_full), 32'h0);
            if (i == 6) check("full_after7", 32'(uart_full), 32'h1);
            if (i == 7) check("no_ovf_at8", 32'(overflow), 32'h0);
        end
        check("ovf_after9", 32'(overflow), 32'h1);
        access(1'b0, 32'h0003_0004, 8'h00);
        check("count_full", 32'(dout), 32'h8);

        // Halt, then reset mid-drain with a UART write on the bus
        access(1'b1, 32'h0003_0004, 8'hFF);
        check("halt_set", 32'(halt), 32'h1);
        tx_ready = 1'b1;
        access(1'b0, 32'h0000_0010, 8'h00);
        do_reset(1'b1);
        access(1'b0, 32'h0003_0004, 8'h00);
        check("count_after_rst", 32'(dout), 32'h0);

        // Drain order
        tx_ready = 1'b0;
        access(1'b1, 32'h0003_0000, 8'h41);
        access(1'b1, 32'h0003_0000, 8'h42);
        access(1'b1, 32'h0003_0000, 8'h43);
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("drain%0d", i), 32'(tx_data), 32'(8'h41 + i));
            idle();
        end
        check("drained_valid", 32'(tx_valid), 32'h0);
        access(1'b0, 32'h0003_0004, 8'h00);
        check("drained_count", 32'(dout), 32'h0);

        // Push+pop at full with wrapped pointers
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) access(1'b1, 32'h0003_0000, 8'(8'h20 + i));
        check("refill_full", 32'(uart_full), 32'h1);
        check("refill_no_ovf", 32'(overflow), 32'h0);
        tx_ready = 1'b1;
        access(1'b1, 32'h0003_0000, 8'h5A);
        check("pp_no_ovf", 32'(overflow), 32'h0);
        check("pp_full", 32'(uart_full), 32'h1);
        for (int i = 0; i < 7; i++) drain_exp[i] = 8'(8'h21 + i);
        drain_exp[7] = 8'h5A;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("pp_valid%0d", i), 32'(tx_valid), 32'h1);
            check($sformatf("pp_data%0d", i), 32'(tx_data), 32'(drain_exp[i]));
            idle();
        end
        check("pp_empty", 32'(tx_valid), 32'h0);
        access(1'b0, 32'h0003_0004, 8'h00);
        check("pp_count", 32'(dout), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
